// File: rtl/a2d_spi_resp.sv
// SPI slave answering an A2D-style master: returns the conversion value of the
// channel latched from the previous frame while capturing the next channel address.
module a2d_spi_resp #(
  parameter logic [2:0] INIT_CH = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ch_data,
  output logic [2:0]  ch_addr,
  output logic        cmd_vld,
  output logic        frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic        ss_s1_q, ss_s2_q, ss_s3_q;
  logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic        mosi_s1_q, mosi_s2_q;
  logic [15:0] shft_q, shft_d;
  logic [15:0] cmd_q, cmd_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        first_fall_q, first_fall_d;
  logic [2:0]  ch_addr_q, ch_addr_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        frame_err_q, frame_err_d;
  logic        sclk_rise, sclk_fall, ss_fall, ss_rise;

  // Select and clock idle high, so their syncs come out of reset inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_s3_q   <= 1'b1;
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_s3_q <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      ss_s1_q   <= SS_n;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign ss_fall   = ~ss_s2_q & ss_s3_q;
  assign ss_rise   = ss_s2_q & ~ss_s3_q;

  always_comb begin
    state_d      = state_q;
    shft_d       = shft_q;
    cmd_d        = cmd_q;
    bit_cnt_d    = bit_cnt_q;
    first_fall_d = first_fall_q;
    ch_addr_d    = ch_addr_q;
    cmd_vld_d    = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d      = SHIFT;
          shft_d       = {4'h0, ch_data};
          bit_cnt_d    = 5'd0;
          first_fall_d = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == 5'd16) begin
            ch_addr_d = cmd_q[13:11];
            cmd_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          cmd_d = (cmd_q << 1) | {15'd0, mosi_s2_q};
          if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (sclk_fall) begin
          // The leading fall only parks the clock low; the MSB is already on MISO.
          if (first_fall_q) first_fall_d = 1'b0;
          else              shft_d       = shft_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shft_q       <= 16'd0;
      cmd_q        <= 16'd0;
      bit_cnt_q    <= 5'd0;
      first_fall_q <= 1'b0;
      ch_addr_q    <= INIT_CH;
      cmd_vld_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shft_q       <= shft_d;
      cmd_q        <= cmd_d;
      bit_cnt_q    <= bit_cnt_d;
      first_fall_q <= first_fall_d;
      ch_addr_q    <= ch_addr_d;
      cmd_vld_q    <= cmd_vld_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign MISO      = ~ss_s2_q & shft_q[15];
  assign ch_addr   = ch_addr_q;
  assign cmd_vld   = cmd_vld_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: directed frame table, reset corner cases and random
// frames checked against a frame-level model of the responder.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] ch_data;
  logic [2:0]  ch_addr;
  logic        cmd_vld, frame_err;

  logic        lut_mode;
  logic [11:0] ch_data_drv;
  logic [11:0] lut [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // A2D model: in lut mode the converter presents the value of the addressed channel.
  assign ch_data = lut_mode ? lut[ch_addr] : ch_data_drv;

  a2d_spi_resp #(.INIT_CH(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .ch_data(ch_data), .ch_addr(ch_addr),
    .cmd_vld(cmd_vld), .frame_err(frame_err)
  );

  typedef struct {
    logic [15:0] word;
    int          nr;
    logic [15:0] exp_miso;
    logic [2:0]  exp_addr;
    logic        exp_vld;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] word, input int nr, input logic scramble,
                           output logic [15:0] miso_w, output int vld_cnt, output int err_cnt,
                           output int vld_at, output int err_at, output int both,
                           output logic miso_after);
    miso_w = 16'h0; vld_cnt = 0; err_cnt = 0; vld_at = -1; err_at = -1; both = 0;
    miso_after = 1'b0;
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nr; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? word[15-i] : 1'b0;
      wait_clk(5);
      if (i < 16) miso_w[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(5);
      if (scramble && i == 4) ch_data_drv = 12'($urandom);
    end
    wait_clk(4);
    SS_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_clk(1);
      if (cmd_vld)   begin vld_cnt++; if (vld_at < 0) vld_at = k; end
      if (frame_err) begin err_cnt++; if (err_at < 0) err_at = k; end
      if (cmd_vld && frame_err) both++;
      if (k == 3) miso_after = MISO;
    end
  endtask

  // Frame-level reference: a 16-rise frame is a valid command, anything else an error.
  logic [2:0] model_addr;

  task automatic frame_and_check(input string tag, input logic [15:0] word, input int nr,
                                 input logic scramble, input logic [15:0] exp_resp);
    logic [15:0] mw;
    logic        ma;
    int vc, ec, va, ea, bo;
    logic [31:0] mask32;
    logic [15:0] mask;
    mask32 = (nr >= 16) ? 32'hFFFF : ((32'hFFFF << (16 - nr)) & 32'hFFFF);
    mask   = mask32[15:0];
    run_frame(word, nr, scramble, mw, vc, ec, va, ea, bo, ma);
    if (nr == 16) model_addr = word[13:11];
    check({tag, " miso"}, mw & mask, exp_resp & mask);
    check({tag, " vld_cnt"}, vc, (nr == 16) ? 1 : 0);
    check({tag, " err_cnt"}, ec, (nr == 16) ? 0 : 1);
    check({tag, " pulse_at"}, (nr == 16) ? va : ea, 3);
    check({tag, " both"}, bo, 0);
    check({tag, " miso_idle"}, ma, 1'b0);
    check({tag, " ch_addr"}, ch_addr, model_addr);
  endtask

  vec_t vecs [7];

  initial begin
    logic [15:0] w;
    logic [11:0] held;
    int nr;
    int pulses;

    lut[0] = 12'h5A3; lut[1] = 12'h1C1; lut[2] = 12'h2D2; lut[3] = 12'h3E3;
    lut[4] = 12'h4F4; lut[5] = 12'h605; lut[6] = 12'h716; lut[7] = 12'h827;

    vecs[0] = '{16'h1800, 16, 16'h05A3, 3'd3, 1'b1};
    vecs[1] = '{16'h0800, 16, 16'h03E3, 3'd1, 1'b1};
    vecs[2] = '{16'h2000, 16, 16'h01C1, 3'd4, 1'b1};
    vecs[3] = '{16'h3800, 12, 16'h04F4, 3'd4, 1'b0};
    vecs[4] = '{16'h1000, 18, 16'h04F4, 3'd4, 1'b0};
    vecs[5] = '{16'h17FF, 16, 16'h04F4, 3'd2, 1'b1};
    vecs[6] = '{16'hE800, 16, 16'h02D2, 3'd5, 1'b1};

    // Reset state with a live converter value present.
    lut_mode = 1'b0; ch_data_drv = 12'hABC;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    model_addr = 3'd0;
    wait_clk(3);
    check("rst miso", MISO, 1'b0);
    check("rst ch_addr", ch_addr, 3'd0);
    check("rst pulses", {cmd_vld, frame_err}, 2'b00);
    rst_n = 1'b1;
    wait_clk(3);

    // SCLK activity with select high must be ignored.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      SCLK = ~SCLK; MOSI = ~MOSI;
      wait_clk(4);
      if (cmd_vld || frame_err) pulses++;
      if (MISO) pulses++;
    end
    SCLK = 1'b1;
    wait_clk(6);
    check("idle sclk activity", pulses, 0);
    check("idle ch_addr", ch_addr, 3'd0);

    // Directed frames, converter following ch_addr.
    lut_mode = 1'b1;
    for (int v = 0; v < 7; v++) begin
      frame_and_check($sformatf("vec%0d", v), vecs[v].word, vecs[v].nr, 1'b0, vecs[v].exp_miso);
      check($sformatf("vec%0d tbl_addr", v), ch_addr, vecs[v].exp_addr);
      check($sformatf("vec%0d tbl_kind", v), (vecs[v].nr == 16), vecs[v].exp_vld);
    end

    // Reset asserted mid-frame after 8 bits.
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; wait_clk(5);
      SCLK = 1'b1; wait_clk(5);
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst async ch_addr", ch_addr, 3'd0);
    check("midrst async miso", MISO, 1'b0);
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    model_addr = 3'd0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      wait_clk(1);
      if (cmd_vld || frame_err) pulses++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_clk(1);
      if (cmd_vld || frame_err) pulses++;
    end
    check("midrst pulses", pulses, 0);
    check("midrst ch_addr", ch_addr, 3'd0);
    frame_and_check("post_rst", 16'h3000, 16, 1'b0, 16'h05A3);

    // Random frames; ch_data is scrambled mid-frame and must not leak to MISO.
    lut_mode = 1'b0;
    for (int r = 0; r < 20; r++) begin
      w  = 16'($urandom);
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      ch_data_drv = 12'($urandom);
      held = ch_data_drv;
      frame_and_check($sformatf("rnd%0d", r), w, nr, 1'b1, {4'h0, held});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 SHALL have parameter INIT_CH, default 3'd0: channel address in effect before the first valid command.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port SS_n  input  1  SPI slave select from the A2D master, active-low.
REQ-005 SHALL have port SCLK  input  1  SPI clock; idles high.
REQ-006 SHALL have port MOSI  input  1  serial command from the master, MSB first.
REQ-007 SHALL have port MISO  output  1  serial response to the master, MSB first.
REQ-008 SHALL have port ch_data  input  12  conversion value for the channel on ch_addr.
REQ-009 SHALL have port ch_addr  output  3  channel latched from the last valid command.
REQ-010 SHALL have port cmd_vld  output  1  one-clk pulse when a valid 16-bit frame completes.
REQ-011 SHALL have port frame_err  output  1  one-clk pulse when a frame ends with a bit count other than 16.

Function
REQ-012 SHALL synchronize SS_n, SCLK and MOSI through two flops each; the SS_n and SCLK syncs preset to 1 and the MOSI sync resets to 0.
REQ-013 SHALL derive SCLK rise/fall and SS_n fall/rise strobes from a third registered stage of the synchronized signals.
REQ-014 SHALL implement the FSM states IDLE and SHIFT.
REQ-015 IDLE SHALL go to SHIFT on the SS_n-fall strobe.
REQ-016 SHALL load shft[15:0] = {4'h0, ch_data} on the SS_n-fall strobe, so the response carries the channel addressed by the previous frame.
REQ-017 SHALL clear bit_cnt and set first_fall on the SS_n-fall strobe.
REQ-018 In SHIFT, the SCLK-rise strobe SHALL shift the synchronized MOSI into cmd[15:0] LSB-side.
REQ-019 In SHIFT, the SCLK-rise strobe SHALL increment bit_cnt, saturating at 17.
REQ-020 In SHIFT, the first SCLK-fall strobe after SS_n fall SHALL be ignored and SHALL clear first_fall.
REQ-021 In SHIFT, each later SCLK-fall strobe SHALL shift shft left, filling with 0.
REQ-022 MISO SHALL equal shft[15] while the synchronized SS_n is low, and SHALL be 0 otherwise.
REQ-023 SHIFT SHALL return to IDLE on the SS_n-rise strobe.
REQ-024 On the SS_n-rise strobe, if bit_cnt==16, ch_addr SHALL take cmd[13:11] and cmd_vld SHALL pulse for exactly one clk.
REQ-025 On the SS_n-rise strobe, if bit_cnt!=16, ch_addr SHALL hold and frame_err SHALL pulse for exactly one clk.
REQ-026 cmd_vld and frame_err SHALL each rise exactly 3 clk after the SS_n rising edge at the port, given setup to clk.
REQ-027 cmd_vld and frame_err SHALL never be high in the same cycle.
REQ-028 SCLK edges while in IDLE SHALL change no state.
REQ-029 An SS_n-fall strobe in SHIFT (a glitch) SHALL NOT occur by construction; if the sync sees rise and fall in consecutive cycles, the FSM SHALL process each in order.
REQ-030 ch_data SHALL be sampled only in the SS_n-fall strobe cycle; changes during a frame SHALL NOT affect MISO.
REQ-031 A frame of more than 16 rises SHALL produce frame_err and SHALL leave ch_addr unchanged.
REQ-032 cmd bits other than [13:11] SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force FSM=IDLE, shft=0, cmd=0, bit_cnt=0, first_fall=0, ch_addr=INIT_CH, cmd_vld=0, frame_err=0 and MISO=0.
REQ-034 rst_n low mid-frame SHALL discard the frame without a cmd_vld or frame_err pulse.
REQ-035 After rst_n rises, the block SHALL wait for a fresh SS_n-fall strobe before responding.

Verification
REQ-036 Reset: ch_data=12'hABC, rst_n low -> MISO=0, ch_addr=0, and no pulses.
REQ-037 Single frame: ch_data=12'h5A3, MOSI word 16'h1800 (ch 3) -> MISO bits 16'h05A3, ch_addr=3, one cmd_vld pulse 3 clk after SS_n rise.
REQ-038 Back-to-back frames: ch1 then ch4, with ch_data following ch_addr -> second frame returns the ch1 value and ch_addr ends at 4.
REQ-039 Short frame: 12 SCLK rises -> frame_err pulses once, ch_addr unchanged, no cmd_vld.
REQ-040 Long frame: 18 SCLK rises -> frame_err pulses once and the next frame still behaves normally.
REQ-041 Reset mid-frame after 8 bits -> no pulses, ch_addr=INIT_CH, and the next full frame returns the correct value.
